// File: rtl/cpu_conf_loader.sv
// Boots a soft CPU over its 134-bit config packet path: halt (sel=1), program
// writes streamed from program memory in WORDS_PER_PKT segments, release (sel=0).
module cpu_conf_loader #(
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_PKT = 64,
    parameter int GAP_CYCLES    = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              data_out_valid,
    output logic [133:0]      data_out
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int PW = $clog2(WORDS_PER_PKT + 1);
    localparam logic [127:0] HEAD_SEL = 128'h1111_2222_3333_4444_5555_6666_9001_0000;
    localparam logic [127:0] HEAD_PRG = 128'h1111_2222_3333_4444_5555_6666_9003_0000;
    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b00;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    // State names describe what the registered outputs show in that cycle.
    typedef enum logic [3:0] {
        S_IDLE, S_GAP, S_SEL_HEAD, S_SEL_DATA, S_SEL_PAD2, S_SEL_PAD1,
        S_PRG_HEAD, S_PRG_BODY, S_FIN
    } state_e;
    typedef enum logic [1:0] {PH_SEL1, PH_PRG, PH_SEL0} phase_e;

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [ADDR_W:0]     rdptr_q, rdptr_d;
    logic [PW-1:0]       pktrem_q, pktrem_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                rden_q, rden_d, valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [133:0]        data_q, data_d;
    logic [15:0]         addr16;
    logic [ADDR_W:0]     len_clamped;
    logic                emit_body;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        gcnt_d      = gcnt_q;
        remain_d    = remain_q;
        rdptr_d     = rdptr_q;
        pktrem_d    = pktrem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rden_d      = 1'b0;
        addr_d      = addr_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        addr16      = '0;
        addr16[ADDR_W-1:0] = addr_q;
        len_clamped = prog_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : prog_len;
        emit_body   = (state_q == S_PRG_HEAD) || (state_q == S_PRG_BODY && pktrem_q != '0);

        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_GAP;
                phase_d  = PH_SEL1;
                gcnt_d   = '0;
                busy_d   = 1'b1;
                remain_d = len_clamped;
                rdptr_d  = '0;
            end
            S_GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    gcnt_d  = '0;
                    valid_d = 1'b1;
                    if (phase_q == PH_PRG) begin
                        state_d  = S_PRG_HEAD;
                        data_d   = {TAG_HEAD, 4'hf, HEAD_PRG};
                        rden_d   = 1'b1;
                        addr_d   = rdptr_q[ADDR_W-1:0];
                        rdptr_d  = rdptr_q + 1'b1;
                        pktrem_d = (32'(remain_q) > 32'(WORDS_PER_PKT)) ?
                                   PW'(WORDS_PER_PKT) : PW'(remain_q);
                    end else begin
                        state_d = S_SEL_HEAD;
                        data_d  = {TAG_HEAD, 4'hf, HEAD_SEL};
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            S_SEL_HEAD: begin
                state_d = S_SEL_DATA;
                valid_d = 1'b1;
                data_d  = {TAG_MID, 4'hf, 111'b0, phase_q == PH_SEL1, 16'b0};
            end
            S_SEL_DATA: begin
                state_d = S_SEL_PAD2;
                valid_d = 1'b1;
                data_d  = {TAG_MID, 4'hf, 128'b0};
            end
            S_SEL_PAD2: begin
                state_d = S_SEL_PAD1;
                valid_d = 1'b1;
                data_d  = {TAG_TAIL, 4'hf, 128'b0};
            end
            S_SEL_PAD1: begin
                if (phase_q == PH_SEL0) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_GAP;
                    phase_d = (remain_q != '0) ? PH_PRG : PH_SEL0;
                end
            end
            S_PRG_HEAD: state_d = S_PRG_BODY;
            S_PRG_BODY: if (pktrem_q == '0) begin
                state_d = S_GAP;
                phase_d = (remain_q != '0) ? PH_PRG : PH_SEL0;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Body word = data read in the previous cycle; prefetch next unless last.
        if (emit_body) begin
            valid_d  = 1'b1;
            data_d   = {(pktrem_q == PW'(1)) ? TAG_TAIL : TAG_MID, 4'hf,
                        48'b0, mem_rdata, 16'b0, addr16, 16'b0};
            pktrem_d = pktrem_q - 1'b1;
            remain_d = remain_q - 1'b1;
            if (pktrem_q != PW'(1)) begin
                rden_d  = 1'b1;
                addr_d  = rdptr_q[ADDR_W-1:0];
                rdptr_d = rdptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_SEL1;
            gcnt_q   <= '0;
            remain_q <= '0;
            rdptr_q  <= '0;
            pktrem_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            gcnt_q   <= gcnt_d;
            remain_q <= remain_d;
            rdptr_q  <= rdptr_d;
            pktrem_q <= pktrem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rden_q   <= rden_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_rden       = rden_q;
    assign mem_addr       = addr_q;
    assign data_out_valid = valid_q;
    assign data_out       = data_q;
endmodule
